// File: rtl/seven_seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with decimal points.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module seven_seg #(
  parameter int unsigned DIGIT_CYCLES = 65536,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic [7:0] code [4];
  logic [3:0] blank;
  logic [7:0] cur_code;

  assign code[0] = display_0;
  assign code[1] = display_1;
  assign code[2] = display_2;
  assign code[3] = display_3;

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] pat(input logic [3:0] nib);
    logic [6:0] p;
    unique case (nib)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

`ifdef SEVENSEG_LZB_EN
  logic lead;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      blank[i] = (code[i][7:4] != 4'h0);
    end
`ifdef SEVENSEG_LZB_EN
    // A zero is blanked while every digit above it is zero or itself blank.
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (code[i] == 8'h00)) blank[i] = 1'b1;
      lead = lead && ((code[i] == 8'h00) || (code[i][7:4] != 4'h0));
    end
`endif
  end

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    cur_code = code[idx_q];
    an_d     = ~(4'b0001 << idx_q);
    seg_d[7] = (idx_q != decplace);
    seg_d[6:0] = blank[idx_q] ? 7'h7F : ~pat(cur_code[3:0]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg.sv
// Self-checking bench for seven_seg: scoreboard of expected {an,seg} plus directed checks.
// Leading-zero expectations follow SEVENSEG_LZB_EN.
module tb_seven_seg;
  localparam int unsigned DigitCycles = 4;
  localparam int unsigned CntW        = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
  logic [1:0] dp = 2'd0;
  logic [7:0] seg;
  logic [3:0] an;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_q [$];
  int          m_cnt;
  int          m_idx;

  localparam logic [6:0] Pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg #(
    .DIGIT_CYCLES(DigitCycles),
    .CNT_W       (CntW)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .display_0(d0),
    .display_1(d1),
    .display_2(d2),
    .display_3(d3),
    .decplace (dp),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  // Reference decode straight from the display rules.
  function automatic logic [7:0] ref_seg(input int idx, input logic [31:0] codes,
                                         input logic [1:0] p);
    logic [7:0] c [4];
    logic       blk;
    for (int i = 0; i < 4; i++) c[i] = codes[8*i +: 8];
    blk = (c[idx] >= 8'h10);
`ifdef SEVENSEG_LZB_EN
    if (idx > 0 && c[idx] == 8'h00) begin
      blk = 1'b1;
      for (int j = idx + 1; j < 4; j++)
        if (!(c[j] == 8'h00 || c[j] >= 8'h10)) blk = 1'b0;
    end
`endif
    return {(idx != int'(p)), blk ? 7'h7F : ~Pat[c[idx][3:0]]};
  endfunction

  initial begin
    m_cnt = 0;
    m_idx = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_cnt = 0;
        m_idx = 0;
        exp_q.delete();
      end else begin
        exp_q.push_back({~(4'b0001 << m_idx), ref_seg(m_idx, {d3, d2, d1, d0}, dp)});
        if (m_cnt == int'(DigitCycles) - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rstn && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("sb", {an, seg}, e);
      end
    end
  end

  task automatic do_reset(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] a3, input logic [1:0] p);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    d0 = a0; d1 = a1; d2 = a2; d3 = a3; dp = p;
    @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] an_seq [4];
    logic [7:0] code;
    logic [7:0] cap [4];
    bit         found;
    an_seq = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Reset and first digits
    d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04; dp = 2'd2;
    #3 rstn = 1'b0;
    #1 check_eq("reset", {an, seg}, 12'hFFF);
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1 check_eq("first_e", {an, seg}, {4'hE, 8'hF9});
    repeat (4) @(posedge clk);
    #1 check_eq("then_d", {an, seg}, {4'hD, 8'hA4});

    // Scan order, hold time and DP position
    for (int k = 6; k <= 17; k++) begin
      @(posedge clk);
      #1 check_eq("scan", {3'b0, an, seg[7]},
                  {3'b0, an_seq[((k - 1) / 4) % 4], (((k - 1) / 4) % 4 == 2) ? 1'b0 : 1'b1});
    end

    // Hex decode sweep on digit 0 plus out-of-range codes
    for (int i = 0; i < 18; i++) begin
      code = (i < 16) ? 8'(i) : ((i == 16) ? 8'h10 : 8'hFF);
      do_reset(code, 8'h01, 8'h02, 8'h03, 2'd1);
      @(posedge clk);
      #1 check_eq("hex", {5'b0, seg[6:0]}, {5'b0, (i < 16) ? ~Pat[i] : 7'h7F});
    end

    // decplace change mid digit 0
    do_reset(8'h01, 8'h02, 8'h03, 8'h04, 2'd2);
    @(posedge clk); #1 check_eq("dp_off", {11'b0, seg[7]}, 12'h001);
    @(negedge clk); #2 dp = 2'd0;
    @(posedge clk); #1 check_eq("dp_on", {11'b0, seg[7]}, 12'h000);

    // Reset mid-scan at an=B
    dp = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1 if (an == 4'hB) found = 1'b1;
    end
    check_eq("find_b", {11'b0, found}, 12'h001);
    rstn = 1'b0;
    #1 check_eq("mid_reset", {an, seg}, 12'hFFF);
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1 check_eq("restart", {8'b0, an}, 12'h00E);

    // Leading zeros: d3..d0 = 00 00 07 03
    do_reset(8'h03, 8'h07, 8'h00, 8'h00, 2'd3);
    for (int i = 0; i < 4; i++) cap[i] = 8'h00;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #1;
      case (an)
        4'hE: cap[0] = seg;
        4'hD: cap[1] = seg;
        4'hB: cap[2] = seg;
        4'h7: cap[3] = seg;
        default: ;
      endcase
    end
`ifdef SEVENSEG_LZB_EN
    check_eq("lz_d3", {5'b0, cap[3][6:0]}, 12'h07F);
    check_eq("lz_d2", {4'b0, cap[2]}, 12'h0FF);
`else
    check_eq("lz_d3", {5'b0, cap[3][6:0]}, 12'h040);
    check_eq("lz_d2", {4'b0, cap[2]}, 12'h0C0);
`endif
    check_eq("lz_d1", {4'b0, cap[1]}, 12'h0F8);
    check_eq("lz_d0", {4'b0, cap[0]}, 12'h0B0);

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
